fetch_queue_param: RTL and testbench
====================================

// Module: fetch_queue_param
// PURPOSE
// Parametrised decoupling queue between fetch/BPU and decode, generalising the fixed dual-issue instbuffer.
// Accepts up to FETCH_W in-order instructions per cycle with pc and prediction info.
// Issues up to ISSUE_W per cycle to decode under a per-lane ready prefix.
// Supports branch flush and pipeline stall.
// PARAMETERS
// FETCH_W  2   instructions pushed per accepted fetch bundle (1..4)
// ISSUE_W  2   max instructions popped per cycle (1..4)
// DEPTH    32  entries; power of two, >= 2*max(FETCH_W,ISSUE_W)
// PORTS
// clk                 in   1           clock
// rst                 in   1           synchronous reset, active-low (0 = reset)
// flush_i             in   1           branch flush; discard all contents
// stall_i             in   1           decode stall; no pop this cycle
// fetch_valid_i       in   FETCH_W     lane valids; must be a contiguous prefix (lane0 first)
// fetch_pc_i          in   FETCH_W*32  per-lane pc, lane i at [32i+:32]
// fetch_inst_i        in   FETCH_W*32  per-lane instruction
// fetch_pred_taken_i  in   FETCH_W     per-lane BPU taken prediction
// fetch_pred_addr_i   in   FETCH_W*32  per-lane predicted target
// fetch_ready_o       out  1           queue can accept a full FETCH_W bundle
// issue_valid_o       out  ISSUE_W     lane i holds the i-th oldest entry
// issue_ready_i       in   ISSUE_W     decode accepts lane i; must be a prefix
// issue_pc_o          out  ISSUE_W*32  per-lane pc
// issue_inst_o        out  ISSUE_W*32  per-lane instruction
// issue_pred_taken_o  out  ISSUE_W     per-lane prediction
// issue_pred_addr_o   out  ISSUE_W*32  per-lane predicted target
// BEHAVIOUR
// - State: circular RAM, head/tail pointers log2(DEPTH) bits (wrap modulo DEPTH), count log2(DEPTH)+1 bits.
// - Reset (rst==0 at posedge): head=tail=count=0; RAM not cleared.
//   Outputs after reset: issue_valid_o=0, fetch_ready_o=1. Inputs ignored while rst==0.
// - fetch_ready_o = (DEPTH-count >= FETCH_W); combinational from registered count only (no same-cycle pop credit).
// - Push: if fetch_ready_o && |fetch_valid_i && !flush_i, write npush=popcount(fetch_valid_i) lanes at tail..tail+npush-1.
//   tail += npush. Lanes are written in lane order, wrapping past DEPTH-1 to 0.
//   Push with fetch_ready_o==0 is dropped; the producer must hold the bundle.
// - Issue view: issue_valid_o[i] = (count > i) && !stall_i.
//   Lane i data = RAM[head+i mod DEPTH], combinational read. Data is don't-care when lane invalid.
// - Pop: npop = popcount(issue_valid_o & issue_ready_i); head += npop.
//   A non-prefix ready pattern is an assertion error.
// - count_next = count + npush - npop; push and pop in the same cycle are legal, including at full-minus-FETCH_W and at empty.
//   Empty: no pop. Push data is visible on issue lanes the next cycle (latency 1).
// - flush_i has priority: head=tail=count=0 next cycle; same-cycle push and pop are suppressed.
// - Reset has priority over flush_i. A reset mid-operation discards contents identically.
// - Invariant: 0 <= count <= DEPTH; overflow or underflow is impossible by construction and is asserted in simulation.
// CONFIGURATION
// FETCH_QUEUE_PERF_EN defined adds two outputs:
//   perf_full_cycles_o [31:0]: cycles with fetch_ready_o==0.
//   perf_issued_o [31:0]: running sum of npop.
//   Both reset to 0, wrap at 2^32, and are not cleared by flush.
// FETCH_QUEUE_PERF_EN undefined: the ports and counters do not exist; all other behaviour is identical.
// TESTING
// 1 Reset then push bundle pc=0x1c000000/04 (FETCH_W=2), issue_ready=0 -> next cycle issue_valid=2'b11, pc lanes 0x1c000000/04, count=2.
// 2 Push every cycle with stall_i=1 -> fetch_ready_o drops when count=31 (DEPTH=32, free=1<2); held bundle is not written.
// 3 Fill to DEPTH, then simultaneous push and pop of 2 -> push rejected (ready based on registered count), count=30 next cycle.
// 4 head=30, pop 2 per cycle across wrap -> lane order 30,31,0,1 preserved, pcs strictly +4.
// 5 flush_i asserted with a valid push and issue_ready=11 -> next cycle count=0, issue_valid=0, no entry written or popped.
// 6 issue_ready=2'b01 with 2 valid -> exactly 1 popped; lane1 entry moves to lane0 next cycle.

Source files
------------

// File: rtl/fetch_queue_param.sv
// ---------------------------------------------------------------------------
// fetch_queue_param
//
// Purpose:
//   Parametrised decoupling queue between fetch/BPU and decode. Up to FETCH_W
//   in-order instructions, each with its pc and branch prediction, are
//   accepted per cycle. Up to ISSUE_W of the oldest entries are presented to
//   decode per cycle, and decode takes them under a per-lane ready prefix.
//   A branch flush empties the queue. A decode stall hides all issue lanes
//   for the cycle.
//
// Parameters:
//   FETCH_W  lanes per fetch bundle (1..4)
//   ISSUE_W  maximum entries popped per cycle (1..4)
//   DEPTH    entries; power of two, >= 2*max(FETCH_W, ISSUE_W)
//
// Ports:
//   clk                 clock
//   rst                 synchronous reset, active-low (0 = reset)
//   flush_i             discard all contents; has priority over push and pop
//   stall_i             decode stall; all issue lanes read as invalid
//   fetch_valid_i       lane valids, contiguous prefix starting at lane 0
//   fetch_pc_i          per-lane pc, lane i at [32i+:32]
//   fetch_inst_i        per-lane instruction word
//   fetch_pred_taken_i  per-lane BPU taken prediction
//   fetch_pred_addr_i   per-lane predicted target
//   fetch_ready_o       room for a full FETCH_W bundle
//   issue_valid_o       lane i holds the i-th oldest entry
//   issue_ready_i       decode accepts lane i; contiguous prefix
//   issue_pc_o          per-lane pc
//   issue_inst_o        per-lane instruction word
//   issue_pred_taken_o  per-lane taken prediction
//   issue_pred_addr_o   per-lane predicted target
//
// Optional feature (macro FETCH_QUEUE_PERF_EN):
//   perf_full_cycles_o  cycles in which fetch_ready_o was 0
//   perf_issued_o       running sum of entries popped
//   Both counters clear only on reset (not on flush) and wrap at 2^32.
//   With the macro undefined these ports and counters do not exist.
// ---------------------------------------------------------------------------
module fetch_queue_param #(
  parameter int FETCH_W = 2,
  parameter int ISSUE_W = 2,
  parameter int DEPTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic                 stall_i,
  input  logic [FETCH_W-1:0]   fetch_valid_i,
  input  logic [FETCH_W*32-1:0] fetch_pc_i,
  input  logic [FETCH_W*32-1:0] fetch_inst_i,
  input  logic [FETCH_W-1:0]   fetch_pred_taken_i,
  input  logic [FETCH_W*32-1:0] fetch_pred_addr_i,
  output logic                 fetch_ready_o,
  output logic [ISSUE_W-1:0]   issue_valid_o,
  input  logic [ISSUE_W-1:0]   issue_ready_i,
  output logic [ISSUE_W*32-1:0] issue_pc_o,
  output logic [ISSUE_W*32-1:0] issue_inst_o,
  output logic [ISSUE_W-1:0]   issue_pred_taken_o,
  output logic [ISSUE_W*32-1:0] issue_pred_addr_o
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0]          perf_full_cycles_o,
  output logic [31:0]          perf_issued_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] FETCH_W_C = CNT_W'(FETCH_W);

  // Storage: one array per field, no reset (contents are qualified by count)
  logic [31:0] pc_mem    [DEPTH];
  logic [31:0] inst_mem  [DEPTH];
  logic        taken_mem [DEPTH];
  logic [31:0] addr_mem  [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             push_en;
  logic [CNT_W-1:0] npush;
  logic [CNT_W-1:0] npop;
  logic [ISSUE_W-1:0] pop_lanes;

  // Number of set bits in a fetch-side lane mask
  function automatic logic [CNT_W-1:0] popcnt_fetch(input logic [FETCH_W-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      n = n + CNT_W'(v[i]);
    end
    return n;
  endfunction

  // Number of set bits in an issue-side lane mask
  function automatic logic [CNT_W-1:0] popcnt_issue(input logic [ISSUE_W-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      n = n + CNT_W'(v[i]);
    end
    return n;
  endfunction

  // Ready looks only at the registered count, so a pop in the same cycle
  // never frees room for a push in that cycle.
  assign fetch_ready_o = ((DEPTH_C - count_q) >= FETCH_W_C);

  assign push_en = fetch_ready_o && (|fetch_valid_i) && !flush_i;
  assign npush   = push_en ? popcnt_fetch(fetch_valid_i) : '0;

  // Issue view: lane i shows the i-th oldest entry by combinational read.
  // Stall masks every lane, which also blocks any pop this cycle.
  always_comb begin
    issue_valid_o      = '0;
    issue_pc_o         = '0;
    issue_inst_o       = '0;
    issue_pred_taken_o = '0;
    issue_pred_addr_o  = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      issue_valid_o[i]          = (count_q > CNT_W'(i)) && !stall_i;
      issue_pc_o[32*i +: 32]    = pc_mem[head_q + PTR_W'(i)];
      issue_inst_o[32*i +: 32]  = inst_mem[head_q + PTR_W'(i)];
      issue_pred_taken_o[i]     = taken_mem[head_q + PTR_W'(i)];
      issue_pred_addr_o[32*i +: 32] = addr_mem[head_q + PTR_W'(i)];
    end
  end

  // Flush wins over the handshake, so nothing is popped in a flush cycle
  assign pop_lanes = flush_i ? '0 : (issue_valid_o & issue_ready_i);
  assign npop      = popcnt_issue(pop_lanes);

  // Next-state for pointers and occupancy. Flush empties the queue; otherwise
  // head and tail advance by the number popped and pushed respectively.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_W'(npop);
      tail_d  = tail_q + PTR_W'(npush);
      count_d = count_q + npush - npop;
    end
  end

  // Pointer/occupancy registers; reset dominates flush
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry write: valid lanes form a prefix, so lane i lands at tail+i and
  // the pointer arithmetic wraps naturally past DEPTH-1.
  always_ff @(posedge clk) begin
    if (rst && push_en) begin
      for (int i = 0; i < FETCH_W; i++) begin
        if (fetch_valid_i[i]) begin
          pc_mem[tail_q + PTR_W'(i)]    <= fetch_pc_i[32*i +: 32];
          inst_mem[tail_q + PTR_W'(i)]  <= fetch_inst_i[32*i +: 32];
          taken_mem[tail_q + PTR_W'(i)] <= fetch_pred_taken_i[i];
          addr_mem[tail_q + PTR_W'(i)]  <= fetch_pred_addr_i[32*i +: 32];
        end
      end
    end
  end

`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] perf_full_q, perf_full_d;
  logic [31:0] perf_issued_q, perf_issued_d;

  // Performance counters keep counting across flushes
  always_comb begin
    perf_full_d   = perf_full_q + {31'd0, !fetch_ready_o};
    perf_issued_d = perf_issued_q + 32'(npop);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_full_q   <= '0;
      perf_issued_q <= '0;
    end else begin
      perf_full_q   <= perf_full_d;
      perf_issued_q <= perf_issued_d;
    end
  end

  assign perf_full_cycles_o = perf_full_q;
  assign perf_issued_o      = perf_issued_q;
`endif

  // Interface contract checks: both lane masks must be contiguous prefixes,
  // and occupancy can never leave [0, DEPTH].
  always_ff @(posedge clk) begin
    if (rst) begin
      assert ((issue_ready_i & (issue_ready_i + ISSUE_W'(1))) == '0);
      assert ((fetch_valid_i & (fetch_valid_i + FETCH_W'(1))) == '0);
      assert (count_q <= DEPTH_C);
      assert (npop <= count_q);
    end
  end

endmodule

// File: tb/tb_fetch_queue_param.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue_param
//
// Scoreboard bench for fetch_queue_param (FETCH_W=2, ISSUE_W=2, DEPTH=32).
// Every accepted fetch lane is pushed to a queue as an expected entry; each
// cycle the issue lanes are compared with the head of that queue, and the
// entries decode takes are popped.
// ---------------------------------------------------------------------------
module tb_fetch_queue_param;

  localparam int FW    = 2;
  localparam int IW    = 2;
  localparam int DEPTH = 32;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        taken;
    logic [31:0] addr;
  } entry_t;

  logic              clk;
  logic              rst;
  logic              flush_i;
  logic              stall_i;
  logic [FW-1:0]     fetch_valid_i;
  logic [FW*32-1:0]  fetch_pc_i;
  logic [FW*32-1:0]  fetch_inst_i;
  logic [FW-1:0]     fetch_pred_taken_i;
  logic [FW*32-1:0]  fetch_pred_addr_i;
  logic              fetch_ready_o;
  logic [IW-1:0]     issue_valid_o;
  logic [IW-1:0]     issue_ready_i;
  logic [IW*32-1:0]  issue_pc_o;
  logic [IW*32-1:0]  issue_inst_o;
  logic [IW-1:0]     issue_pred_taken_o;
  logic [IW*32-1:0]  issue_pred_addr_o;

  entry_t      sb[$];
  logic [31:0] nextPc;
  int          checks;
  int          failures;

  fetch_queue_param #(.FETCH_W(FW), .ISSUE_W(IW), .DEPTH(DEPTH)) dut (
    .clk                (clk),
    .rst                (rst),
    .flush_i            (flush_i),
    .stall_i            (stall_i),
    .fetch_valid_i      (fetch_valid_i),
    .fetch_pc_i         (fetch_pc_i),
    .fetch_inst_i       (fetch_inst_i),
    .fetch_pred_taken_i (fetch_pred_taken_i),
    .fetch_pred_addr_i  (fetch_pred_addr_i),
    .fetch_ready_o      (fetch_ready_o),
    .issue_valid_o      (issue_valid_o),
    .issue_ready_i      (issue_ready_i),
    .issue_pc_o         (issue_pc_o),
    .issue_inst_o       (issue_inst_o),
    .issue_pred_taken_o (issue_pred_taken_o),
    .issue_pred_addr_o  (issue_pred_addr_o)
  );

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Derived per-entry fields so every lane carries distinct, checkable data
  function automatic entry_t makeEntry(input logic [31:0] pc);
    entry_t e;
    e.pc    = pc;
    e.inst  = (pc * 32'd3) ^ 32'h5A5A_0F0F;
    e.taken = pc[2] ^ pc[4];
    e.addr  = pc + 32'h0000_0140;
    return e;
  endfunction

  // Single comparison point: counts and reports a mismatch
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs after the falling edge, check outputs against
  // the scoreboard, then advance the model at the rising edge.
  task automatic applyStimulus(input logic rstV, input logic flushV, input logic stallV,
                               input logic [1:0] fvalid, input logic [1:0] iready);
    entry_t e;
    logic   expReady;
    logic   expValid;
    int     npop;
    int     nsz;
    @(negedge clk);
    rst           = rstV;
    flush_i       = flushV;
    stall_i       = stallV;
    fetch_valid_i = fvalid;
    issue_ready_i = iready;
    for (int i = 0; i < FW; i++) begin
      e = makeEntry(nextPc + 32'(4 * i));
      fetch_pc_i[32*i +: 32]        = e.pc;
      fetch_inst_i[32*i +: 32]      = e.inst;
      fetch_pred_taken_i[i]         = e.taken;
      fetch_pred_addr_i[32*i +: 32] = e.addr;
    end
    #1;
    nsz      = sb.size();
    expReady = ((DEPTH - nsz) >= FW);
    npop     = 0;
    if (rstV) begin
      checkOutput("fetch_ready", {31'd0, fetch_ready_o}, {31'd0, expReady});
      for (int i = 0; i < IW; i++) begin
        expValid = (nsz > i) && !stallV;
        checkOutput($sformatf("lane%0d_valid", i), {31'd0, issue_valid_o[i]}, {31'd0, expValid});
        if (expValid) begin
          checkOutput($sformatf("lane%0d_pc", i), issue_pc_o[32*i +: 32], sb[i].pc);
          checkOutput($sformatf("lane%0d_inst", i), issue_inst_o[32*i +: 32], sb[i].inst);
          checkOutput($sformatf("lane%0d_taken", i), {31'd0, issue_pred_taken_o[i]}, {31'd0, sb[i].taken});
          checkOutput($sformatf("lane%0d_addr", i), issue_pred_addr_o[32*i +: 32], sb[i].addr);
          if (iready[i]) npop++;
        end
      end
    end
    @(posedge clk);
    if (!rstV || flushV) begin
      sb.delete();
    end else begin
      repeat (npop) void'(sb.pop_front());
      if (expReady && (|fvalid)) begin
        for (int i = 0; i < FW; i++) begin
          if (fvalid[i]) begin
            sb.push_back(makeEntry(nextPc));
            nextPc = nextPc + 32'd4;
          end
        end
      end
    end
  endtask

  // Random legal lane prefix: 00, 01 or 11
  function automatic logic [1:0] randPrefix();
    int r;
    r = $urandom_range(0, 2);
    return (r == 0) ? 2'b00 : ((r == 1) ? 2'b01 : 2'b11);
  endfunction

  initial begin
    checks             = 0;
    failures           = 0;
    nextPc             = 32'h1c00_0000;
    rst                = 1'b0;
    flush_i            = 1'b0;
    stall_i            = 1'b0;
    fetch_valid_i      = '0;
    issue_ready_i      = '0;
    fetch_pc_i         = '0;
    fetch_inst_i       = '0;
    fetch_pred_taken_i = '0;
    fetch_pred_addr_i  = '0;

    $display("[TB] reset and first bundle");
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b11, 2'b11);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b11, 2'b11);
    nextPc = 32'h1c00_0000;
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b11, 2'b00);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 2'b00);

    $display("[TB] single-lane pushes under stall until ready drops");
    for (int c = 0; c < 34; c++) applyStimulus(1'b1, 1'b0, 1'b1, 2'b01, 2'b11);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 2'b00);

    $display("[TB] full queue, push with simultaneous pop");
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    for (int c = 0; c < 16; c++) applyStimulus(1'b1, 1'b0, 1'b0, 2'b11, 2'b00);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b11, 2'b11);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 2'b00);

    $display("[TB] pointer wrap");
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    for (int c = 0; c < 15; c++) applyStimulus(1'b1, 1'b0, 1'b0, 2'b11, 2'b00);
    for (int c = 0; c < 15; c++) applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 2'b11);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b11, 2'b00);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b11, 2'b00);
    for (int c = 0; c < 3; c++) applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 2'b11);

    $display("[TB] flush with push and pop requested");
    for (int c = 0; c < 3; c++) applyStimulus(1'b1, 1'b0, 1'b0, 2'b11, 2'b00);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'b11, 2'b11);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 2'b00);

    $display("[TB] partial ready prefix");
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b11, 2'b00);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 2'b01);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 2'b01);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 2'b00);

    $display("[TB] random traffic");
    for (int c = 0; c < 600; c++) begin
      applyStimulus((c == 300) ? 1'b0 : 1'b1,
                    ($urandom_range(0, 39) == 0),
                    ($urandom_range(0, 3) == 0),
                    randPrefix(),
                    randPrefix());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
